// File: rtl/audio_event_arbiter.sv
// rtl/audio_event_arbiter.sv - speaker arbiter playing TONE1/GAP/TONE2 for the highest-priority pending sound source
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   trig         per-source level trigger; a rising edge requests playback
//   mute         forces speaker_out low without touching sequencing
//   speaker_out  square-wave audio output
//   busy         high while in TONE1, GAP or TONE2
//   active_src   index of the playing source; holds its last value when idle
//   done         one-cycle pulse on the final TONE2 cycle of a completed sequence
//
// Optional macro AUDIO_ARB_PREEMPT_EN: a pending source with a higher index than
// the playing one aborts the current sequence and starts directly in TONE1.

module audio_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int HALF_W = 18,
  parameter logic [NUM_SRC*HALF_W-1:0] HALF_PERIODS =
    {18'd128061, 18'd113636, 18'd95556, 18'd63776},
  parameter int TONE1_CYC = 3125000,
  parameter int GAP_CYC = 3125000,
  parameter int TONE2_CYC = 6250000,
  parameter int DUR_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         trig,
  input  logic                       mute,
  output logic                       speaker_out,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic                       done
);

  localparam int SW = $clog2(NUM_SRC);
  localparam logic [DUR_W-1:0] T1_LAST  = DUR_W'(TONE1_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_CYC - 1);
  localparam logic [DUR_W-1:0] T2_LAST  = DUR_W'(TONE2_CYC - 1);

  typedef enum logic [1:0] {IDLE, TONE1, GAP, TONE2} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] trig_prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] grant_mask;
  logic [DUR_W-1:0]   timer;
  logic [HALF_W-1:0]  hcnt;
  logic [HALF_W-1:0]  half_per;
  logic               tone_bit;
  logic               any_pend;
  logic [SW-1:0]      top_src;
  logic               phase_end;
  logic               preempt;
  logic               grant;

  assign edges = trig & ~trig_prev;

  // Ascending scan: the last set bit seen is the highest-priority request.
  always_comb begin
    top_src  = '0;
    any_pend = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i]) begin
        top_src  = SW'(i);
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    half_per = HALF_PERIODS[int'(active_src)*HALF_W +: HALF_W];
  end

  always_comb begin
    case (state)
      TONE1:   phase_end = (timer == T1_LAST);
      GAP:     phase_end = (timer == GAP_LAST);
      TONE2:   phase_end = (timer == T2_LAST);
      default: phase_end = 1'b0;
    endcase
  end

`ifdef AUDIO_ARB_PREEMPT_EN
  assign preempt = (state != IDLE) && any_pend && (top_src > active_src);
`else
  assign preempt = 1'b0;
`endif

  assign grant      = any_pend && ((state == IDLE) || preempt);
  assign grant_mask = grant ? (NUM_SRC'(1) << top_src) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_prev  <= '0;
      pending    <= '0;
      timer      <= '0;
      hcnt       <= '0;
      tone_bit   <= 1'b0;
      active_src <= '0;
    end else begin
      trig_prev <= trig;
      // A new edge on the bit being granted wins over the clear.
      pending   <= (pending & ~grant_mask) | edges;
      if (grant) begin
        active_src <= top_src;
        state      <= TONE1;
        timer      <= '0;
        hcnt       <= '0;
        tone_bit   <= 1'b0;
      end else begin
        case (state)
          TONE1, TONE2: begin
            if (phase_end) begin
              state    <= (state == TONE1) ? GAP : IDLE;
              timer    <= '0;
              hcnt     <= '0;
              tone_bit <= 1'b0;
            end else begin
              timer <= timer + DUR_W'(1);
              if (hcnt == half_per - HALF_W'(1)) begin
                hcnt     <= '0;
                tone_bit <= ~tone_bit;
              end else begin
                hcnt <= hcnt + HALF_W'(1);
              end
            end
          end
          GAP: begin
            if (phase_end) begin
              state <= TONE2;
              timer <= '0;
            end else begin
              timer <= timer + DUR_W'(1);
            end
          end
          default: begin
            timer <= '0;
          end
        endcase
      end
    end
  end

  // Tone bit starts at 0, so every tone phase begins with a high half-period.
  assign speaker_out = ((state == TONE1) || (state == TONE2)) & ~tone_bit & ~mute;
  assign busy        = (state != IDLE);
  assign done        = (state == TONE2) && phase_end && !preempt;

endmodule

// File: tb/tb_audio_event_arbiter.sv
// tb/tb_audio_event_arbiter.sv - randomized and directed self-checking bench for audio_event_arbiter

module tb_audio_event_arbiter;

  localparam int T1 = 20;
  localparam int GP = 10;
  localparam int T2 = 20;
  localparam int SEQ = T1 + GP + T2;

`ifdef AUDIO_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] trig = 4'b0;
  logic       mute = 1'b0;
  logic       speaker_out;
  logic       busy;
  logic [1:0] active_src;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  audio_event_arbiter #(
    .NUM_SRC(4),
    .HALF_W(18),
    .HALF_PERIODS({18'd5, 18'd4, 18'd3, 18'd2}),
    .TONE1_CYC(T1),
    .GAP_CYC(GP),
    .TONE2_CYC(T2),
    .DUR_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trig(trig),
    .mute(mute),
    .speaker_out(speaker_out),
    .busy(busy),
    .active_src(active_src),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a request set plus a position within the 50-cycle sequence.
  int         hp_tab [4] = '{2, 3, 4, 5};
  logic [3:0] m_pend = '0;
  logic [3:0] m_prev = '0;
  logic       m_busy = 1'b0;
  int         m_src = 0;
  int         m_pos = 0;
  int         m_h;
  logic       m_take;
  logic       m_pre;
  logic [3:0] m_clr;
  logic       exp_spk;
  logic       exp_done;

  function automatic int hi_idx(input logic [3:0] p);
    int r = -1;
    for (int i = 0; i < 4; i++) if (p[i]) r = i;
    return r;
  endfunction

  always_comb begin
    m_h    = hi_idx(m_pend);
    m_pre  = PRE && m_busy && (m_h > m_src);
    m_take = (!m_busy && (m_h >= 0)) || m_pre;
    m_clr  = 4'b0;
    if (m_take) m_clr[m_h] = 1'b1;
  end

  always_comb begin
    exp_spk  = 1'b0;
    exp_done = m_busy && (m_pos == SEQ - 1) && !m_pre;
    if (m_busy && !mute) begin
      if (m_pos < T1)
        exp_spk = ((m_pos / hp_tab[m_src]) % 2) == 0;
      else if (m_pos >= T1 + GP)
        exp_spk = (((m_pos - T1 - GP) / hp_tab[m_src]) % 2) == 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0;
      m_prev <= '0;
      m_busy <= 1'b0;
      m_src  <= 0;
      m_pos  <= 0;
    end else begin
      m_prev <= trig;
      m_pend <= (m_pend & ~m_clr) | (trig & ~m_prev);
      if (m_take) begin
        m_busy <= 1'b1;
        m_src  <= m_h;
        m_pos  <= 0;
      end else if (m_busy) begin
        if (m_pos == SEQ - 1) begin
          m_busy <= 1'b0;
          m_pos  <= 0;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(exp_done));
    chk("model_speaker", 32'(speaker_out), 32'(exp_spk));
    chk("model_active_src", 32'(active_src), 32'(m_src[1:0]));
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 500) begin
      step();
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 3) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout actual=%0d cycles required=idle", n);
    end
  endtask

  // Returns edges elapsed since the request edge when done is seen.
  task automatic wait_done(input int start, output int off);
    off = start;
    while (!done && off < 200) begin
      step();
      off++;
    end
  endtask

  int off;
  int base;
  logic [3:0] pat;

  initial begin
    // Reset with trigger activity
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      trig = ~trig;
      step();
      chk("reset_busy", 32'(busy), 0);
      chk("reset_speaker", 32'(speaker_out), 0);
      chk("reset_done", 32'(done), 0);
    end
    @(negedge clk);
    trig = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_reset_idle", 32'(busy), 0);

    // Single request on source 0 (half-period 2)
    @(negedge clk);
    trig = 4'b0001;
    step();
    chk("single_busy_k", 32'(busy), 0);
    trig = 4'b0000;
    step();
    chk("single_busy_k1", 32'(busy), 1);
    pat[3] = speaker_out;
    for (int i = 2; i >= 0; i--) begin
      step();
      pat[i] = speaker_out;
    end
    chk("single_pattern", 32'(pat), 32'b1100);
    wait_done(4, off);
    chk("single_done_offset", off, SEQ);
    step();
    chk("single_busy_end", 32'(busy), 0);
    wait_idle();

    // Muted sequence keeps identical timing
    mute = 1'b1;
    @(negedge clk);
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    step();
    chk("mute_busy", 32'(busy), 1);
    chk("mute_speaker", 32'(speaker_out), 0);
    wait_done(1, off);
    chk("mute_done_offset", off, SEQ);
    mute = 1'b0;
    wait_idle();

    // Simultaneous sources 1 and 3
    base = done_cnt;
    @(negedge clk);
    trig = 4'b1010;
    step();
    trig = 4'b0000;
    step();
    chk("simul_first_src", 32'(active_src), 3);
    wait_done(1, off);
    chk("simul_first_done", off, SEQ);
    step();
    chk("simul_idle_gap", 32'(busy), 0);
    step();
    chk("simul_second_busy", 32'(busy), 1);
    chk("simul_second_src", 32'(active_src), 1);
    wait_idle();
    chk("simul_done_count", done_cnt - base, 2);

    // Held level gives exactly one sequence
    base = done_cnt;
    @(negedge clk);
    trig = 4'b0100;
    repeat (100) @(negedge clk);
    trig = 4'b0000;
    wait_idle();
    chk("held_done_count", done_cnt - base, 1);

    // Two re-edges during playback give exactly one replay
    base = done_cnt;
    @(negedge clk);
    trig = 4'b0100;
    @(negedge clk);
    trig = 4'b0000;
    for (int r = 0; r < 2; r++) begin
      repeat (10) @(negedge clk);
      trig = 4'b0100;
      @(negedge clk);
      trig = 4'b0000;
    end
    wait_idle();
    chk("reedge_done_count", done_cnt - base, 2);

    // Higher source arrives during TONE1 of source 0
    base = done_cnt;
    @(negedge clk);
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    repeat (5) step();
    trig = 4'b1000;
    step();
    chk("preempt_src_before", 32'(active_src), 0);
    trig = 4'b0000;
    step();
`ifdef AUDIO_ARB_PREEMPT_EN
    chk("preempt_src_after", 32'(active_src), 3);
    chk("preempt_speaker", 32'(speaker_out), 1);
    wait_idle();
    chk("preempt_done_count", done_cnt - base, 1);
`else
    chk("nopreempt_src_after", 32'(active_src), 0);
    wait_idle();
    chk("nopreempt_done_count", done_cnt - base, 2);
`endif

    // Randomized triggers, mute and occasional reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) trig[b] = ~trig[b];
      end
      if ($urandom_range(0, 31) == 0) mute = ~mute;
    end
    @(negedge clk);
    rst_n = 1'b1;
    trig = 4'b0000;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_event_arbiter.md
Name: audio_event_arbiter

Overview:
- Shares the single speaker pin between the game's sound-effect sources (car collision, lose, win, hop).
- Detects a rising edge on each source's trigger and latches it as pending.
- Grants the highest-priority pending source and plays a fixed three-phase pattern at that source's square-wave pitch: TONE1, GAP, TONE2.
- Sits between the game-state FSM trigger outputs and the top-level speaker output.

Parameters:
- NUM_SRC, 4: number of requesters; index NUM_SRC-1 has the highest priority.
- HALF_W, 18: width of each half-period value.
- HALF_PERIODS, {18'd128061,18'd113636,18'd95556,18'd63776}: packed per-source half-period in clk cycles; source i occupies bits [i*HALF_W +: HALF_W].
- TONE1_CYC, 3125000: length of the first tone phase in cycles.
- GAP_CYC, 3125000: length of the silent phase in cycles.
- TONE2_CYC, 6250000: length of the second tone phase in cycles.
- DUR_W, 24: width of the phase timer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  NUM_SRC  level trigger per source; a rising edge requests playback.
- mute  in  1  forces speaker_out to 0; sequencing continues.
- speaker_out  out  1  square-wave audio output.
- busy  out  1  high while in TONE1, GAP or TONE2.
- active_src  out  $clog2(NUM_SRC)  index of the source currently playing; holds its last value when idle.
- done  out  1  one-cycle pulse when a sequence completes TONE2 normally.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; trig_prev, pending, timers and half-counter all 0.
  - speaker_out=0, busy=0, active_src=0, done=0.
- Edge detect: trig_prev<=trig. Edge_i = trig[i] & ~trig_prev[i]. Edge_i sets pending[i] at that same clk edge.
- Grant: in IDLE with pending!=0, select the highest set index s.
  - pending[s]<=0, active_src<=s, state<=TONE1; timer, half-counter and tone bit <=0.
  - Latency: edge sampled at clk edge k gives busy=1 and speaker_out=1 after edge k+1.
- TONE1: lasts exactly TONE1_CYC cycles.
  - Tone bit toggles when half-counter reaches HALF_PERIODS[s]-1; counter then wraps to 0.
  - speaker_out = ~tone_bit & ~mute, so the first half-period is high.
- GAP: lasts GAP_CYC cycles; speaker_out=0; half-counter and tone bit are cleared on entry.
- TONE2: same as TONE1 for TONE2_CYC cycles, restarting high.
  - On the final cycle: done=1 for one cycle and state<=IDLE.
  - If any pending bit is set, the next grant happens in that IDLE cycle (one idle cycle between sequences).
- Phase timer: counts 0..len-1, then resets to 0 on each phase change. A phase length of 0 is illegal and not checked.
- Edges from the currently playing source or lower-priority sources while busy set pending and are served later. A repeat edge on an already-pending source is absorbed, giving one replay.
- Edge on source s while playing s: replays s after completion.
- Simultaneous edges: all latch; served in descending index order.
- Edge in the same cycle a grant clears that bit: the set wins, so pending stays 1.
- Reset mid-sequence: output to 0 immediately; all pending requests are lost.
- mute never alters timing, state, done or busy.

Optional Feature:
- Macro AUDIO_ARB_PREEMPT_EN.
- Defined:
  - While busy, a pending source with index > active_src aborts the current sequence at the next clk edge.
  - The current sequence is discarded (not resumed, no done pulse).
  - The new source is granted directly into TONE1 without an IDLE cycle, so speaker_out=1 on that edge.
- Undefined: no preemption; every granted sequence runs to completion.

Test Plan:
All scenarios use NUM_SRC=4, HALF_PERIODS={5,4,3,2}, TONE1_CYC=20, GAP_CYC=10, TONE2_CYC=20.
- Reset check: hold rst_n=0, toggle trig -> speaker_out=0, busy=0, done=0; pending stays 0 after release.
- Single request: trig[0] rising at edge k -> busy=1 at k+1; speaker_out pattern 1,1,0,0 repeating for 20 cycles; 10 cycles of 0; 20 cycles of the pattern; done pulse at cycle k+50; busy=0 at k+51.
- Simultaneous trig[1] and trig[3]: active_src=3 (half-period 5) first; after its done, one idle cycle, then active_src=1 (half-period 3); two done pulses total.
- Held level and re-edge: trig[2] held high for 100 cycles -> exactly one sequence. Trig[2] pulsed twice during playback -> exactly one replay.
- Mute: mute=1 throughout a trig[0] sequence -> speaker_out always 0; busy and done timing identical to the single-request case.
- AUDIO_ARB_PREEMPT_EN: trig[0] playing; trig[3] rises at TONE1 cycle 5 -> active_src=3 two edges later, speaker_out=1, no done for source 0. Without the macro: source 0 completes, then source 3 plays.
